shift_reg_n: RTL and testbench

//  Parametrised N-bit shift register with parallel load. Supports bidirectional shifting,

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 89 ++++++++
 rtl/shift_reg_n.sv | 79 +++++++
 tb/tb_shift_reg_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and fill-bit selection for the shift_reg_n datapath and its sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SERIAL = 2'd0,
    SHIFT_ROTATE = 2'd1,
    SHIFT_ARITH  = 2'd2,
    SHIFT_ZERO   = 2'd3
  } shift_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } shift_state_t;

  // Bit entering the vacated end; dir: 0 = right, 1 = left.
  function automatic logic next_fill(input shift_mode_t mode, input logic dir,
                                     input logic a_msb, input logic out_bit,
                                     input logic sin);
    logic f;
    unique case (mode)
      SHIFT_SERIAL: f = sin;
      SHIFT_ROTATE: f = out_bit;
      SHIFT_ARITH:  f = dir ? 1'b0 : a_msb;
      default:      f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer for shift_reg_n: IDLE/RUN/DONE FSM, down-counter, Dir/Mode latch, Busy/Done.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Dir,
  input  shift_mode_t      Mode,
  output logic             do_shift,
  output logic             do_load,
  output logic             eff_dir,
  output shift_mode_t      eff_mode,
  output logic             Busy,
  output logic             Done
);

  shift_state_t     state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_sat;
  logic             dir_q, dir_nxt;
  shift_mode_t      mode_q, mode_nxt;

  assign cnt_sat = (Count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Count;

  always_comb begin
    state_nxt = S_IDLE;
    cnt_nxt   = cnt_q;
    dir_nxt   = dir_q;
    mode_nxt  = mode_q;
    do_shift  = 1'b0;
    do_load   = 1'b0;
    eff_dir   = Dir;
    eff_mode  = Mode;
    unique case (state_q)
      S_RUN: begin
        eff_dir  = dir_q;
        eff_mode = mode_q;
        if (Load) begin
          do_load   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          do_shift  = 1'b1;
          cnt_nxt   = cnt_q - CNT_W'(1);
          state_nxt = (cnt_q == CNT_W'(1)) ? S_DONE : S_RUN;
        end
      end
      S_IDLE, S_DONE: begin
        if (Load) begin
          do_load = 1'b1;
        end else if (Start) begin
          dir_nxt   = Dir;
          mode_nxt  = Mode;
          cnt_nxt   = cnt_sat;
          state_nxt = (Count == '0) ? S_DONE : S_RUN;
        end else if (Shift_En) begin
          do_shift = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Busy/Done are flopped from the next state so they align with state_q.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= SHIFT_SERIAL;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      dir_q   <= dir_nxt;
      mode_q  <= mode_nxt;
      Busy    <= (state_nxt == S_RUN);
      Done    <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: rtl/shift_reg_n.sv
// N-bit shift register with parallel load, four fill modes and auto-sequenced shifts.
// Optional Parity output enabled by defining SHIFT_REG_N_PARITY_EN.
module shift_reg_n
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  input  logic [WIDTH-1:0] D,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] A,
  output logic             Busy,
  output logic             Done
`ifdef SHIFT_REG_N_PARITY_EN
  ,
  output logic             Parity
`endif
);

  logic             do_shift, do_load, eff_dir, out_bit, fill;
  shift_mode_t      eff_mode;
  logic [WIDTH-1:0] a_q, a_nxt;

  shift_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (Load),
    .Shift_En (Shift_En),
    .Start    (Start),
    .Count    (Count),
    .Dir      (Dir),
    .Mode     (shift_mode_t'(Mode)),
    .do_shift (do_shift),
    .do_load  (do_load),
    .eff_dir  (eff_dir),
    .eff_mode (eff_mode),
    .Busy     (Busy),
    .Done     (Done)
  );

  assign out_bit   = eff_dir ? a_q[WIDTH-1] : a_q[0];
  assign Shift_Out = out_bit;
  assign A         = a_q;

  always_comb begin
    fill  = next_fill(eff_mode, eff_dir, a_q[WIDTH-1], out_bit, Shift_In);
    a_nxt = a_q;
    if (do_load)
      a_nxt = D;
    else if (do_shift)
      a_nxt = eff_dir ? {a_q[WIDTH-2:0], fill} : {fill, a_q[WIDTH-1:1]};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) a_q <= '0;
    else        a_q <= a_nxt;
  end

`ifdef SHIFT_REG_N_PARITY_EN
  // Parity is taken from a_nxt so it lands on the same edge as A.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) Parity <= 1'b0;
    else        Parity <= ^a_nxt;
  end
`endif

endmodule

// File: tb/tb_shift_reg_n.sv
// Self-checking bench for shift_reg_n (WIDTH=8): vector table plus multi-cycle sequences.
module tb_shift_reg_n;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Load = 1'b0, Shift_En = 1'b0, Start = 1'b0, Dir = 1'b0, Shift_In = 1'b0;
  logic [3:0] Count = '0;
  logic [1:0] Mode = '0;
  logic [7:0] D = '0;
  logic       Shift_Out, Busy, Done;
  logic [7:0] A;
`ifdef SHIFT_REG_N_PARITY_EN
  logic       Parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_n #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Shift_En  (Shift_En),
    .Start     (Start),
    .Count     (Count),
    .Dir       (Dir),
    .Mode      (Mode),
    .Shift_In  (Shift_In),
    .D         (D),
    .Shift_Out (Shift_Out),
    .A         (A),
    .Busy      (Busy),
    .Done      (Done)
`ifdef SHIFT_REG_N_PARITY_EN
    ,
    .Parity    (Parity)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       load;
    logic [7:0] d;
    logic       shift_en;
    logic       start;
    logic [3:0] count;
    logic       dir;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] exp_a;
    logic       exp_so;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    Load = 1'b0; Shift_En = 1'b0; Start = 1'b0; Count = '0;
  endtask

  initial begin
    int busy_cnt, done_cnt;

    //           load d      sh st cnt  dir mode sin exp_a  so
    vecs[0]  = '{1'b1, 8'hB3, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'hB3, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 8'hD9, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 8'hB2, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0, 8'h65, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 2'd1, 1'b0, 8'hB2, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0, 8'hD9, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 2'd2, 1'b1, 8'hB2, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 2'd3, 1'b1, 8'h59, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 2'd3, 1'b1, 8'hB2, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 8'hB2, 1'b0};
    vecs[10] = '{1'b1, 8'h3C, 1'b1, 1'b1, 4'd5, 1'b0, 2'd0, 1'b1, 8'h3C, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 8'h1E, 1'b0};

    #3;
    chk("reset_a", A, 8'h00);
    chk("reset_busy", {7'd0, Busy}, 8'd0);
    chk("reset_done", {7'd0, Done}, 8'd0);
    chk("reset_so", {7'd0, Shift_Out}, 8'd0);
    step();
    Reset = 1'b1;
    step();

    // Single-cycle operations, Load priority, live Dir/Mode
    for (int i = 0; i < 12; i++) begin
      Load = vecs[i].load; D = vecs[i].d; Shift_En = vecs[i].shift_en;
      Start = vecs[i].start; Count = vecs[i].count; Dir = vecs[i].dir;
      Mode = vecs[i].mode; Shift_In = vecs[i].sin;
      step();
      chk($sformatf("vec%0d_a", i), A, vecs[i].exp_a);
      chk($sformatf("vec%0d_so", i), {7'd0, Shift_Out}, {7'd0, vecs[i].exp_so});
      chk($sformatf("vec%0d_busy", i), {7'd0, Busy}, 8'd0);
      chk($sformatf("vec%0d_done", i), {7'd0, Done}, 8'd0);
    end
    quiet();

    // Arithmetic right x3 with live Dir/Mode changed during RUN
    Load = 1'b1; D = 8'h96; step(); quiet();
    Start = 1'b1; Count = 4'd3; Dir = 1'b0; Mode = 2'd2; step(); quiet();
    Dir = 1'b1; Mode = 2'd3; Shift_In = 1'b1;
    chk("arith_e_a", A, 8'h96);
    chk("arith_e_busy", {7'd0, Busy}, 8'd1);
    chk("arith_so_latched", {7'd0, Shift_Out}, 8'd0);
    step(); chk("arith_1", A, 8'hCB); chk("arith_1_busy", {7'd0, Busy}, 8'd1);
    step(); chk("arith_2", A, 8'hE5); chk("arith_2_busy", {7'd0, Busy}, 8'd1);
    step(); chk("arith_3", A, 8'hF2); chk("arith_3_busy", {7'd0, Busy}, 8'd0);
    chk("arith_done", {7'd0, Done}, 8'd1);
    step(); chk("arith_done_end", {7'd0, Done}, 8'd0); chk("arith_hold", A, 8'hF2);

    // Count saturation: 12 requested, 8 rotate-left shifts
    Load = 1'b1; D = 8'h81; step(); quiet();
    Start = 1'b1; Count = 4'd12; Dir = 1'b1; Mode = 2'd1; step(); quiet();
    Dir = 1'b0; Mode = 2'd0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
      step();
      if (c == 0) chk("rot_first", A, 8'h03);
    end
    chk("rot_busy_cycles", 8'(busy_cnt), 8'd8);
    chk("rot_done_pulses", 8'(done_cnt), 8'd1);
    chk("rot_a", A, 8'h81);

    // Load aborts RUN: no Done pulse
    Load = 1'b1; D = 8'hFF; step(); quiet();
    Start = 1'b1; Count = 4'd5; Dir = 1'b0; Mode = 2'd3; step(); quiet();
    step(); chk("abort_shift1", A, 8'h7F);
    Load = 1'b1; D = 8'h5A; step(); quiet();
    chk("abort_a", A, 8'h5A);
    chk("abort_busy", {7'd0, Busy}, 8'd0);
    chk("abort_done", {7'd0, Done}, 8'd0);
    step(); chk("abort_done2", {7'd0, Done}, 8'd0); chk("abort_idle_busy", {7'd0, Busy}, 8'd0);

    // Count = 0: straight to DONE
    Start = 1'b1; Count = 4'd0; step(); quiet();
    chk("zero_busy", {7'd0, Busy}, 8'd0);
    chk("zero_done", {7'd0, Done}, 8'd1);
    chk("zero_a", A, 8'h5A);
    step(); chk("zero_done_end", {7'd0, Done}, 8'd0);

    // Back-to-back: Start accepted in DONE
    Start = 1'b1; Count = 4'd1; Dir = 1'b1; Mode = 2'd3; step(); quiet();
    chk("b2b_busy", {7'd0, Busy}, 8'd1);
    step(); chk("b2b_a1", A, 8'hB4); chk("b2b_done1", {7'd0, Done}, 8'd1);
    chk("b2b_nobusy", {7'd0, Busy}, 8'd0);
    Start = 1'b1; Count = 4'd2; Dir = 1'b0; Mode = 2'd0; Shift_In = 1'b1; step(); quiet();
    chk("b2b_busy2", {7'd0, Busy}, 8'd1); chk("b2b_done_off", {7'd0, Done}, 8'd0);
    step(); chk("b2b_s1", A, 8'hDA);
    step(); chk("b2b_s2", A, 8'hED); chk("b2b_done2", {7'd0, Done}, 8'd1);
    step();

    // Asynchronous reset mid-sequence
    Start = 1'b1; Count = 4'd5; Dir = 1'b0; Mode = 2'd0; step(); quiet();
    chk("rst_pre_busy", {7'd0, Busy}, 8'd1);
    #1 Reset = 1'b0;
    #1;
    chk("rst_async_a", A, 8'h00);
    chk("rst_async_busy", {7'd0, Busy}, 8'd0);
    chk("rst_async_done", {7'd0, Done}, 8'd0);
    chk("rst_async_so", {7'd0, Shift_Out}, 8'd0);
    #1 Reset = 1'b1;
    step();

`ifdef SHIFT_REG_N_PARITY_EN
    Load = 1'b1; D = 8'h07; step(); quiet();
    chk("par_load", {7'd0, Parity}, 8'd1);
    Shift_En = 1'b1; Dir = 1'b0; Mode = 2'd3; step(); quiet();
    chk("par_shift_a", A, 8'h03);
    chk("par_shift", {7'd0, Parity}, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
